// File: rtl/softmax_ctrl.sv
// softmax_ctrl: frames serial logits, drives the softmax engine,
// then reports the argmax class and its probability.
module softmax_ctrl #(
  parameter  int N_CLASS = 10,
  parameter  int DW      = 32,
  parameter  int TIMEOUT = 15,
  localparam int CW      = $clog2(N_CLASS),
  localparam int TW      = $clog2(TIMEOUT + 1)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  input  logic [DW-1:0]         in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  sm_valid_in,
  output logic [DW*N_CLASS-1:0] sm_d_in,
  input  logic [DW*N_CLASS-1:0] sm_percent,
  input  logic                  sm_valid_out,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [CW-1:0]         res_class,
  output logic [DW-1:0]         res_prob,
  output logic                  err_frame,
  output logic                  err_timeout,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_LOAD,
    S_FIRE,
    S_WAIT,
    S_ARGMAX,
    S_OUT
  } state_t;

  localparam logic [CW-1:0] LAST = CW'(N_CLASS - 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   idx;
  logic [TW-1:0]   wcnt;
  logic [CW-1:0]   best_idx;
  logic [DW-1:0]   best;
  logic [DW-1:0]   lg_q   [N_CLASS];
  logic [DW-1:0]   prob_q [N_CLASS];
  logic            err_frame_q;
  logic            acc;

  assign acc       = in_valid & in_ready;
  assign res_class = best_idx;
  assign res_prob  = best;
  assign err_frame = err_frame_q;
  assign busy      = (state != S_LOAD);

  // State register
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) state <= S_LOAD;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nxt   = state;
    in_ready    = 1'b0;
    sm_valid_in = 1'b0;
    err_timeout = 1'b0;
    res_valid   = 1'b0;
    unique case (state)
      S_LOAD: begin
        in_ready = ~resetn;
        if (in_valid && !resetn && cnt == LAST)
          state_nxt = S_FIRE;
      end
      S_FIRE: begin
        sm_valid_in = 1'b1;
        state_nxt   = S_WAIT;
      end
      S_WAIT: begin
        if (sm_valid_out) begin
          state_nxt = S_ARGMAX;
        end else if (wcnt == TMAX) begin
          err_timeout = 1'b1;
          state_nxt   = S_LOAD;
        end
      end
      S_ARGMAX: begin
        if (idx == LAST) state_nxt = S_OUT;
      end
      S_OUT: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = S_LOAD;
      end
      default: state_nxt = S_LOAD;
    endcase
  end

  // Frame buffer, result capture and argmax datapath
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      cnt         <= '0;
      idx         <= '0;
      wcnt        <= '0;
      best_idx    <= '0;
      best        <= '0;
      err_frame_q <= 1'b0;
      for (int k = 0; k < N_CLASS; k++) begin
        lg_q[k]   <= '0;
        prob_q[k] <= '0;
      end
    end else begin
      err_frame_q <= 1'b0;
      unique case (state)
        S_LOAD: begin
          if (acc) begin
            if (cnt == LAST) begin
              lg_q[cnt] <= in_data;
              cnt       <= '0;
            end else if (in_last) begin
              cnt         <= '0;
              err_frame_q <= 1'b1;
            end else begin
              lg_q[cnt] <= in_data;
              cnt       <= cnt + CW'(1);
            end
          end
        end
        S_FIRE: begin
          wcnt <= '0;
        end
        S_WAIT: begin
          wcnt <= wcnt + TW'(1);
          if (sm_valid_out) begin
            for (int k = 0; k < N_CLASS; k++)
              prob_q[k] <= sm_percent[k*DW +: DW];
            best_idx <= '0;
            best     <= sm_percent[DW-1:0];
            idx      <= CW'(1);
          end
        end
        S_ARGMAX: begin
          if (prob_q[idx][DW-2:0] > best[DW-2:0]) begin
            best     <= prob_q[idx];
            best_idx <= idx;
          end
          idx <= idx + CW'(1);
        end
        S_OUT: begin
        end
        default: begin
        end
      endcase
    end
  end

  // Flatten the logit buffer onto the engine bus
  always_comb begin
    sm_d_in = '0;
    for (int k = 0; k < N_CLASS; k++)
      sm_d_in[k*DW +: DW] = lg_q[k];
  end

endmodule

// File: tb/tb_softmax_ctrl.sv
// tb_softmax_ctrl: table-driven frames against a behavioural
// softmax engine, plus hand sequences for error, timeout, reset.
module tb_softmax_ctrl;

  localparam int N  = 10;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            resetn = 1'b1;
  logic            in_valid = 1'b0;
  logic [DW-1:0]   in_data = '0;
  logic            in_last = 1'b0;
  logic            in_ready;
  logic            sm_valid_in;
  logic [DW*N-1:0] sm_d_in;
  logic [DW*N-1:0] sm_percent = '0;
  logic            sm_valid_out;
  logic            res_valid;
  logic            res_ready = 1'b0;
  logic [3:0]      res_class;
  logic [DW-1:0]   res_prob;
  logic            err_frame;
  logic            err_timeout;
  logic            busy;

  softmax_ctrl dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready),
    .sm_valid_in(sm_valid_in), .sm_d_in(sm_d_in),
    .sm_percent(sm_percent), .sm_valid_out(sm_valid_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_class(res_class), .res_prob(res_prob),
    .err_frame(err_frame), .err_timeout(err_timeout),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic real f2r(logic [31:0] f);
    logic [63:0] b;
    if (f[30:0] == 31'd0) return 0.0;
    b = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0};
    return $bitstoreal(b);
  endfunction

  function automatic logic [31:0] r2f(real r);
    logic [63:0] b;
    logic [23:0] m;
    int e;
    if (r == 0.0) return 32'd0;
    b = $realtobits(r);
    e = int'(b[62:52]) - 1023 + 127;
    m = {1'b0, b[51:29]} + 24'(b[28]);
    if (m[23]) e++;
    return {b[63], 8'(e), m[22:0]};
  endfunction

  function automatic logic [DW*N-1:0] softmax_bits(logic [DW*N-1:0] d);
    real x [N];
    real mx, s;
    logic [DW*N-1:0] o;
    for (int k = 0; k < N; k++) x[k] = f2r(d[k*DW +: DW]);
    mx = x[0];
    for (int k = 1; k < N; k++) if (x[k] > mx) mx = x[k];
    s = 0.0;
    for (int k = 0; k < N; k++) s += $exp(x[k] - mx);
    for (int k = 0; k < N; k++) o[k*DW +: DW] = r2f($exp(x[k] - mx) / s);
    return o;
  endfunction

  function automatic real logit(int kind, int k);
    case (kind)
      0: return real'(k);
      1: return 0.0;
      2: return real'(9 - k);
      3: return (k == 5) ? 3.0 : 0.5;
      4: return (k == 3 || k == 7) ? 2.0 : -1.0;
      default: return real'(k) * 0.25;
    endcase
  endfunction

  // behavioural engine: fixed 4-cycle latency
  logic       eng_en = 1'b1;
  logic       man_vo = 1'b0;
  logic [3:0] pipe = '0;
  always @(posedge clk) begin
    pipe <= {pipe[2:0], sm_valid_in & eng_en};
    if (sm_valid_in) sm_percent <= softmax_bits(sm_d_in);
  end
  assign sm_valid_out = pipe[3] | man_vo;

  typedef struct {
    int kind;
    int gap;
    int rdy_dly;
    int cls;
  } vec_t;

  typedef struct packed {
    logic [3:0]  cls;
    logic [31:0] prob;
  } exp_t;

  exp_t sbq[$];

  task automatic send_word(input logic [31:0] d, input logic last,
                           output int t);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("accept_wait", 0, 1);
    t = cyc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_frame(input vec_t v);
    logic [DW*N-1:0] pk;
    logic [DW*N-1:0] pr;
    exp_t e;
    int t_acc, n;
    logic [3:0]  c0;
    logic [31:0] p0;
    logic stable;
    for (int k = 0; k < N; k++) pk[k*DW +: DW] = r2f(logit(v.kind, k));
    pr = softmax_bits(pk);
    sbq.push_back({4'(v.cls), pr[v.cls*DW +: DW]});
    res_ready = (v.rdy_dly == 0);
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      send_word(pk[k*DW +: DW], k == N - 1, t_acc);
      if (v.gap != 0 && k < N - 1) begin
        @(posedge clk);
        #1;
      end
    end
    @(negedge clk);
    chk("fire_pulse", sm_valid_in, 1);
    n = 0;
    while (!res_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("res_latency", cyc, t_acc + 15);
    e = sbq.pop_front();
    chk("res_class", res_class, e.cls);
    chk("res_prob", res_prob, e.prob);
    if (v.rdy_dly > 0) begin
      c0 = res_class;
      p0 = res_prob;
      stable = 1'b1;
      for (int j = 0; j < v.rdy_dly; j++) begin
        @(negedge clk);
        if (res_valid !== 1'b1 || res_class !== c0 ||
            res_prob !== p0 || in_ready !== 1'b0)
          stable = 1'b0;
      end
      chk("res_hold", stable, 1);
      res_ready = 1'b1;
    end
    @(negedge clk);
    chk("handshake", {res_valid, in_ready}, 2'b01);
    res_ready = 1'b0;
  endtask

  vec_t vt [6];

  initial begin
    int t, n;
    logic bad;
    logic [DW*N-1:0] pk;

    vt[0] = '{kind: 0, gap: 0, rdy_dly: 0,  cls: 9};
    vt[1] = '{kind: 1, gap: 0, rdy_dly: 0,  cls: 0};
    vt[2] = '{kind: 2, gap: 1, rdy_dly: 20, cls: 0};
    vt[3] = '{kind: 3, gap: 0, rdy_dly: 3,  cls: 5};
    vt[4] = '{kind: 4, gap: 1, rdy_dly: 0,  cls: 3};
    vt[5] = '{kind: 5, gap: 0, rdy_dly: 1,  cls: 9};

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_outs", {in_ready, sm_valid_in, res_valid, err_frame,
                     err_timeout, busy}, 6'd0);
    chk("rst_res", {res_class, res_prob}, 36'd0);
    resetn = 1'b0;
    @(negedge clk);
    chk("rel_ready", in_ready, 1);

    for (int i = 0; i < 6; i++) run_frame(vt[i]);

    // all-zero logits give exactly 0.1 for class 0
    run_frame(vt[1]);
    chk("prob_0p1", res_prob, 32'h3DCCCCCD);

    // early in_last on the 4th word
    for (int k = 0; k < N; k++) pk[k*DW +: DW] = r2f(logit(0, k));
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) send_word(pk[k*DW +: DW], k == 3, t);
    @(negedge clk);
    chk("err_frame", err_frame, 1);
    bad = 1'b0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (sm_valid_in || busy || err_frame) bad = 1'b1;
    end
    chk("no_fire", bad, 0);
    run_frame(vt[3]);

    // engine silent: timeout
    eng_en = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) send_word(pk[k*DW +: DW], k == N - 1, t);
    n = 0;
    bad = 1'b0;
    @(negedge clk);
    while (!err_timeout && n < 40) begin
      @(negedge clk);
      if (res_valid) bad = 1'b1;
      n++;
    end
    chk("timeout_cyc", cyc, t + 17);
    @(negedge clk);
    chk("after_to", {in_ready, err_timeout, res_valid, bad}, 4'b1000);

    // reset during WAIT, late engine pulse
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) send_word(pk[k*DW +: DW], k == N - 1, t);
    @(negedge clk);
    @(negedge clk);
    chk("in_wait", busy, 1);
    resetn = 1'b1;
    @(negedge clk);
    chk("mid_rst_outs", {in_ready, sm_valid_in, res_valid, err_frame,
                         err_timeout, busy}, 6'd0);
    chk("mid_rst_data", {res_class, res_prob, sm_d_in == '0}, 37'd1);
    resetn = 1'b0;
    @(negedge clk);
    chk("mid_rel_ready", in_ready, 1);
    @(negedge clk);
    man_vo = 1'b1;
    @(negedge clk);
    man_vo = 1'b0;
    bad = 1'b0;
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      if (res_valid || busy) bad = 1'b1;
    end
    chk("late_pulse", bad, 0);
    eng_en = 1'b1;
    run_frame(vt[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
